// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Loads a program into instruction memory from a byte stream before the core
// is allowed to run. Bytes arrive over a valid/ready handshake, are packed
// little-endian into INST_W-bit words and written to imem from address 0 up.
// The core is held in reset (core_reset_n = 0) until the whole load finishes.
module imem_boot_loader #(
  parameter int INST_W         = 16,
  parameter int I_ADDR_W       = 12,
  parameter int I_MEMORY_DEPTH = 1 << I_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [I_ADDR_W:0]   length,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                imem_we,
  output logic [I_ADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0]   imem_wdata,
  output logic                core_reset_n,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int BYTES_PER_INST = INST_W / 8;
  localparam int BC_W = (BYTES_PER_INST > 1) ? $clog2(BYTES_PER_INST) : 1;

  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES_PER_INST - 1);
  localparam logic [BC_W-1:0]   ONE_B     = 1;
  localparam logic [I_ADDR_W:0] ONE_W     = 1;
  localparam logic [I_ADDR_W:0] DEPTH_LEN = (I_ADDR_W + 1)'(I_MEMORY_DEPTH);

  // Load sequencer states
  localparam logic [2:0] S_HOLD  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]          state_reg, state_next;
  logic [I_ADDR_W:0]   word_cnt_reg, word_cnt_next;
  logic [I_ADDR_W:0]   length_reg, length_next;
  logic [BC_W-1:0]     byte_cnt_reg, byte_cnt_next;
  logic [I_ADDR_W-1:0] waddr_reg, waddr_next;
  logic [INST_W-1:0]   wdata_reg, wdata_next;

  logic in_ready_reg, in_ready_next;
  logic imem_we_reg, imem_we_next;
  logic core_reset_n_reg, core_reset_n_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic error_reg, error_next;

  logic                accept;
  logic                enter_run;
  logic [I_ADDR_W:0]   word_inc;
  logic [INST_W-1:0]   word_asm;

  // in_ready is registered and only ever high in RECV, so it gates acceptance
  assign accept   = (state_reg == S_RECV) && in_valid && in_ready_reg;
  assign word_inc = word_cnt_reg + ONE_W;

  // One byte lane per stream byte of an instruction. The assembled word
  // forwards the byte being accepted this cycle so the final byte can be
  // written without an extra cycle of latency.
  for (genvar gi = 0; gi < BYTES_PER_INST; gi++) begin : g_lane
    logic [7:0] lane_reg;
    logic       lane_hit;

    assign lane_hit = accept && (byte_cnt_reg == BC_W'(gi));

    // Capture the accepted byte into its lane; cleared on reset so a partial
    // word never survives into a later load
    always_ff @(posedge clk) begin
      if (reset) begin
        lane_reg <= '0;
      end else if (lane_hit) begin
        lane_reg <= in_data;
      end
    end

    assign word_asm[8*gi +: 8] = lane_hit ? in_data : lane_reg;
  end

  // Next-state, counters and write address/data selection
  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    length_next   = length_reg;
    waddr_next    = waddr_reg;
    wdata_next    = wdata_reg;
    enter_run     = 1'b0;

    case (state_reg)
      S_HOLD, S_RUN, S_ERR: begin
        if (start) begin
          if (length == '0) begin
            state_next = S_RUN;
            enter_run  = 1'b1;
          end else if (length > DEPTH_LEN) begin
            state_next = S_ERR;
          end else begin
            state_next    = S_RECV;
            length_next   = length;
            word_cnt_next = '0;
            byte_cnt_next = '0;
          end
        end
      end

      S_RECV: begin
        if (accept) begin
          if (byte_cnt_reg == LAST_BYTE) begin
            state_next    = S_WRITE;
            byte_cnt_next = '0;
            waddr_next    = word_cnt_reg[I_ADDR_W-1:0];
            wdata_next    = word_asm;
          end else begin
            byte_cnt_next = byte_cnt_reg + ONE_B;
          end
        end
      end

      S_WRITE: begin
        // word_cnt is one bit wider than the address, so a full-depth load
        // reaches length without wrapping
        word_cnt_next = word_inc;
        byte_cnt_next = '0;
        if (word_inc == length_reg) begin
          state_next = S_RUN;
          enter_run  = 1'b1;
        end else begin
          state_next = S_RECV;
        end
      end

      default: begin
        state_next = S_HOLD;
      end
    endcase
  end

  // Registered outputs are decoded from the state being entered
  always_comb begin
    in_ready_next     = (state_next == S_RECV);
    imem_we_next      = (state_next == S_WRITE);
    busy_next         = (state_next == S_RECV) || (state_next == S_WRITE);
    core_reset_n_next = (state_next == S_RUN);
    done_next         = enter_run;
    error_next        = (state_next == S_ERR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_HOLD;
      word_cnt_reg     <= '0;
      byte_cnt_reg     <= '0;
      length_reg       <= '0;
      waddr_reg        <= '0;
      wdata_reg        <= '0;
      in_ready_reg     <= 1'b0;
      imem_we_reg      <= 1'b0;
      core_reset_n_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      word_cnt_reg     <= word_cnt_next;
      byte_cnt_reg     <= byte_cnt_next;
      length_reg       <= length_next;
      waddr_reg        <= waddr_next;
      wdata_reg        <= wdata_next;
      in_ready_reg     <= in_ready_next;
      imem_we_reg      <= imem_we_next;
      core_reset_n_reg <= core_reset_n_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      error_reg        <= error_next;
    end
  end

  assign in_ready     = in_ready_reg;
  assign imem_we      = imem_we_reg;
  assign imem_waddr   = waddr_reg;
  assign imem_wdata   = wdata_reg;
  assign core_reset_n = core_reset_n_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: scoreboard of expected imem writes, one task
// per scenario, outputs sampled on the falling edge.
module tb_imem_boot_loader;

  localparam int INST_W   = 16;
  localparam int I_ADDR_W = 12;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [I_ADDR_W:0]   length;
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                imem_we;
  logic [I_ADDR_W-1:0] imem_waddr;
  logic [INST_W-1:0]   imem_wdata;
  logic                core_reset_n;
  logic                busy;
  logic                done;
  logic                error;

  int assertions = 0;
  int failures   = 0;
  int n_writes   = 0;
  int n_done     = 0;
  int cyc        = 0;
  logic prev_we  = 1'b0;
  logic [I_ADDR_W-1:0] last_waddr = '0;

  logic [I_ADDR_W+INST_W-1:0] sb_q[$];

  imem_boot_loader #(
    .INST_W        (INST_W),
    .I_ADDR_W      (I_ADDR_W),
    .I_MEMORY_DEPTH(1 << I_ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .length      (length),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .core_reset_n(core_reset_n),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Write monitor: every imem write is popped against the scoreboard
  always @(negedge clk) begin
    logic [I_ADDR_W+INST_W-1:0] exp_w;
    cyc++;
    if (imem_we) begin
      n_writes++;
      last_waddr = imem_waddr;
      if (imem_waddr < 4 || imem_waddr == 12'hFFF)
        $display("write addr=%h data=%h", imem_waddr, imem_wdata);
      assertions++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_write: in_ready=%b required 0", in_ready);
      end
      assertions++;
      if (prev_we) begin
        failures++;
        $display("FAIL we_one_cycle: imem_we high two cycles, addr=%h", imem_waddr);
      end
      assertions++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr=%h data=%h required no write", imem_waddr, imem_wdata);
      end else begin
        exp_w = sb_q.pop_front();
        if ({imem_waddr, imem_wdata} !== exp_w) begin
          failures++;
          $display("FAIL write_data: got addr=%h data=%h required addr=%h data=%h",
                   imem_waddr, imem_wdata, exp_w[INST_W +: I_ADDR_W], exp_w[INST_W-1:0]);
        end
      end
    end
    if (done === 1'b1) n_done++;
    prev_we = imem_we;
  end

  // Hard stop if something hangs beyond every per-wait bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [I_ADDR_W:0] len);
    start  = 1'b1;
    length = len;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Present one byte and return on the falling edge after it was accepted
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      assertions++;
      failures++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (core_reset_n !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (core_reset_n !== 1'b1) begin
      failures++;
      $display("FAIL %s_run_timeout: core_reset_n=%b required 1", name, core_reset_n);
    end
    assertions++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_on_entry: done=%b required 1", name, done);
    end
    @(negedge clk);
    assertions++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_clear: done=%b required 0", name, done);
    end
  endtask

  task automatic check_reset_values(input string name);
    logic [7:0] got;
    got = {in_ready, imem_we, core_reset_n, busy, done, error, |imem_waddr, |imem_wdata};
    assertions++;
    if (got !== 8'h00) begin
      failures++;
      $display("FAIL %s: outputs {rdy,we,crn,busy,done,err,|addr,|data}=%b required 00000000", name, got);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; length = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset_values");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      assertions++;
      if ({core_reset_n, in_ready, imem_we} !== 3'b000) begin
        failures++;
        $display("FAIL idle_hold: cycle %0d {crn,rdy,we}=%b required 000", i, {core_reset_n, in_ready, imem_we});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int w0 = n_writes, d0 = n_done, c0;
    do_start(13'd3);
    c0 = cyc;
    assertions++;
    if ({busy, in_ready, core_reset_n} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_recv_entry: {busy,rdy,crn}=%b required 110", {busy, in_ready, core_reset_n});
    end
    sb_q.push_back({12'h000, 16'h2211});
    sb_q.push_back({12'h001, 16'h4433});
    sb_q.push_back({12'h002, 16'h6655});
    for (int i = 0; i < 6; i++) send_byte(bytes[i]);
    in_valid = 1'b0;
    wait_run("b2b");
    assertions++;
    if (cyc - c0 != 10) begin
      failures++;
      $display("FAIL b2b_throughput: start-to-done-clear cycles=%0d required 10", cyc - c0);
    end
    assertions++;
    if (n_writes - w0 != 3 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_write_count: writes=%0d pending=%0d required 3/0", n_writes - w0, sb_q.size());
    end
    assertions++;
    if (n_done - d0 != 1) begin
      failures++;
      $display("FAIL b2b_done_count: pulses=%0d required 1", n_done - d0);
    end
  endtask

  task automatic test_toggle_valid();
    logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int w0 = n_writes, d0 = n_done;
    do_start(13'd3);
    sb_q.push_back({12'h000, 16'h2211});
    sb_q.push_back({12'h001, 16'h4433});
    sb_q.push_back({12'h002, 16'h6655});
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i]);
      in_valid = 1'b0;
      in_data  = 8'hEE;
      @(negedge clk);
    end
    wait_run("toggle");
    assertions++;
    if (n_writes - w0 != 3 || sb_q.size() != 0 || n_done - d0 != 1) begin
      failures++;
      $display("FAIL toggle_counts: writes=%0d pending=%0d done=%0d required 3/0/1",
               n_writes - w0, sb_q.size(), n_done - d0);
    end
  endtask

  task automatic test_zero_and_error();
    int w0 = n_writes, d0 = n_done;
    do_start(13'd0);
    assertions++;
    if ({core_reset_n, done, busy} !== 3'b110) begin
      failures++;
      $display("FAIL zero_len_run: {crn,done,busy}=%b required 110", {core_reset_n, done, busy});
    end
    @(negedge clk);
    assertions++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_done_clear: done=%b required 0", done);
    end
    do_start(13'd4097);
    for (int i = 0; i < 5; i++) begin
      assertions++;
      if ({error, core_reset_n, in_ready, busy} !== 4'b1000) begin
        failures++;
        $display("FAIL err_state: cycle %0d {err,crn,rdy,busy}=%b required 1000", i,
                 {error, core_reset_n, in_ready, busy});
      end
      @(negedge clk);
    end
    assertions++;
    if (n_writes != w0 || n_done - d0 != 1) begin
      failures++;
      $display("FAIL zero_err_counts: writes=%0d done=%0d required 0/1", n_writes - w0, n_done - d0);
    end
  endtask

  task automatic test_mid_reset();
    int w0 = n_writes, d0 = n_done;
    do_start(13'd2);
    assertions++;
    if ({error, busy} !== 2'b01) begin
      failures++;
      $display("FAIL err_to_recv: {err,busy}=%b required 01", {error, busy});
    end
    sb_q.push_back({12'h000, 16'hB2A1});
    send_byte(8'hA1);
    in_valid = 1'b0;
    // a start in RECV must not restart or switch to a zero-length load
    do_start(13'd0);
    assertions++;
    if ({busy, core_reset_n} !== 2'b10 || n_done != d0) begin
      failures++;
      $display("FAIL start_in_recv: {busy,crn}=%b done_pulses=%0d required 10/0",
               {busy, core_reset_n}, n_done - d0);
    end
    send_byte(8'hB2);
    send_byte(8'hC3);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset_values");
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hD4;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check_reset_values("post_reset_hold");
    assertions++;
    if (n_writes - w0 != 1 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_writes: writes=%0d pending=%0d required 1/0", n_writes - w0, sb_q.size());
    end
  endtask

  task automatic test_full_load();
    int w0 = n_writes, d0 = n_done;
    logic [15:0] w;
    do_start(13'd4096);
    for (int i = 0; i < 4096; i++) begin
      w = 16'(i * 40503 + 7);
      sb_q.push_back({12'(i), w});
      send_byte(w[7:0]);
      send_byte(w[15:8]);
    end
    in_valid = 1'b0;
    wait_run("full");
    assertions++;
    if (last_waddr !== 12'hFFF) begin
      failures++;
      $display("FAIL full_last_addr: addr=%h required fff", last_waddr);
    end
    repeat (5) @(negedge clk);
    assertions++;
    if (n_writes - w0 != 4096 || sb_q.size() != 0 || n_done - d0 != 1 || core_reset_n !== 1'b1) begin
      failures++;
      $display("FAIL full_counts: writes=%0d pending=%0d done=%0d crn=%b required 4096/0/1/1",
               n_writes - w0, sb_q.size(), n_done - d0, core_reset_n);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_zero_and_error();
    test_mid_reset();
    test_full_load();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
